// File: rtl/pdm_decoder_if.sv
// ============================================================================
// pdm_decoder_if : stereo 1-bit stream inputs and decimated sample outputs
// Revision 1.0
// ============================================================================
`default_nettype none

interface pdm_decoder_if;
    logic        pdm_l;
    logic        pdm_r;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        sample_valid;

    modport master (
        output pdm_l,
        output pdm_r,
        input  left_data,
        input  right_data,
        input  sample_valid
    );

    modport slave (
        input  pdm_l,
        input  pdm_r,
        output left_data,
        output right_data,
        output sample_valid
    );
endinterface

`default_nettype wire

// File: rtl/pdm_decoder.sv
// ============================================================================
// pdm_decoder : stereo first-order sigma-delta stream to 16-bit sample decoder
//               using a sinc^2 CIC decimator of ratio 2^DEC_LOG2 per channel.
// Revision 1.0
// ============================================================================
`default_nettype none

module pdm_decoder #(
    parameter int DEC_LOG2 = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    pdm_decoder_if.slave bus
);

    localparam int W     = 2 * DEC_LOG2 + 1;
    localparam int SHIFT = 16 - 2 * DEC_LOG2;
    localparam logic [DEC_LOG2-1:0] C_DCNT_LAST = '1;
    localparam logic [W-1:0]        C_FULL      = {1'b1, {(2 * DEC_LOG2){1'b0}}};

    logic [DEC_LOG2-1:0] r_dcnt;
    logic                r_fire;
    logic                r_valid;
    logic                w_comb;

    assign w_comb = (r_dcnt == C_DCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt  <= '0;
            r_fire  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_dcnt  <= r_dcnt + 1'b1;
            r_fire  <= w_comb;
            r_valid <= r_fire;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic         w_pin;
        logic         r_s1;
        logic         r_s2;
        logic [W-1:0] r_i1;
        logic [W-1:0] r_i2;
        logic [W-1:0] r_i2_d;
        logic [W-1:0] r_c1_d;
        logic [W-1:0] r_c2;
        logic [W-1:0] w_c1_new;
        logic [15:0]  w_scaled;
        logic [15:0]  r_out;

        assign w_pin    = (ch == 0) ? bus.pdm_l : bus.pdm_r;
        assign w_c1_new = r_i2 - r_i2_d;
        // A full window of ones is the only value that overflows the 16-bit code.
        assign w_scaled = (r_c2 == C_FULL) ? 16'hFFFF
                        : (16'(r_c2[2*DEC_LOG2-1:0]) << SHIFT);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_i1   <= '0;
                r_i2   <= '0;
                r_i2_d <= '0;
                r_c1_d <= '0;
                r_c2   <= '0;
                r_out  <= '0;
            end else begin
                r_s1 <= w_pin;
                r_s2 <= r_s1;
                // Integrators wrap freely; the comb differences cancel the wrap.
                r_i1 <= r_i1 + {{(W-1){1'b0}}, r_s2};
                r_i2 <= r_i2 + r_i1;
                if (w_comb) begin
                    r_i2_d <= r_i2;
                    r_c1_d <= w_c1_new;
                    r_c2   <= w_c1_new - r_c1_d;
                end
                if (r_fire) begin
                    r_out <= w_scaled;
                end
            end
        end
    end

    assign bus.left_data    = g_ch[0].r_out;
    assign bus.right_data   = g_ch[1].r_out;
    assign bus.sample_valid = r_valid;

endmodule

`default_nettype wire
